// File: rtl/accum_warp_stencil_collect_if.sv
// Stream bundle between the stencil-expanded warp source and the summary sink.
// The master drives expanded beats and consumes summary beats; the slave
// (the collector) does the opposite.
interface accum_warp_stencil_collect_if #(
   parameter int N_CFG  = 4,
   parameter int ABW    = 32,
   parameter int WBW    = 8,
   parameter int VDIM   = 3,
   parameter int STSIZE = 8
);
   localparam int NCFG_BW = $clog2(N_CFG + 1);
   localparam int ST_BW   = $clog2(STSIZE + 1);

   // expanded beat stream
   logic                           src_rdy;
   logic                           src_ack;
   logic [NCFG_BW-1:0]             i_id;
   logic [ABW-1:0]                 i_linear;
   logic [VDIM-1:0][WBW-1:0]       i_bofs;
   logic                           i_retire;
   logic                           i_islast;

   // summary beat stream
   logic                           dst_rdy;
   logic                           dst_ack;
   logic [NCFG_BW-1:0]             o_id;
   logic [ABW-1:0]                 o_linear;
   logic [VDIM-1:0][WBW-1:0]       o_bofs;
   logic [ST_BW-1:0]               o_ntap;
   logic                           o_retire;
   logic                           o_islast;
   logic                           o_err;

   modport master (
      output src_rdy, i_id, i_linear, i_bofs, i_retire, i_islast, dst_ack,
      input  src_ack, dst_rdy, o_id, o_linear, o_bofs, o_ntap, o_retire, o_islast, o_err
   );

   modport slave (
      input  src_rdy, i_id, i_linear, i_bofs, i_retire, i_islast, dst_ack,
      output src_ack, dst_rdy, o_id, o_linear, o_bofs, o_ntap, o_retire, o_islast, o_err
   );
endinterface

// File: rtl/accum_warp_stencil_collect.sv
// Collapses a stencil-expanded warp stream into one summary beat per warp.
// Each beat's LUT offset is removed to recover the warp base address, the
// beats of a group are checked against the first one, and taps are counted.
// Parameter defaults mirror the TauCfg configuration values.
module accum_warp_stencil_collect #(
   parameter  int N_CFG   = 4,
   parameter  int ABW     = 32,
   parameter  int WBW     = 8,
   parameter  int VDIM    = 3,
   parameter  int STSIZE  = 8,
   localparam int NCFG_BW = $clog2(N_CFG + 1),
   localparam int ST_BW   = $clog2(STSIZE + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   accum_warp_stencil_collect_if.slave   bus,
   input  logic                          i_stencil,
   input  logic [N_CFG-1:0][ST_BW-1:0]   i_stencil_begs,
   input  logic [N_CFG-1:0][ST_BW-1:0]   i_stencil_ends,
   input  logic [STSIZE-1:0][ABW-1:0]    i_stencil_lut
);
   // open-group state
   logic                       r_ingrp;
   logic [ST_BW-1:0]           r_sid;
   logic [NCFG_BW-1:0]         r_id;
   logic [VDIM-1:0][WBW-1:0]   r_bofs;
   logic [ABW-1:0]             r_base;
   logic [ST_BW-1:0]           r_cnt;
   logic                       r_err_acc;

   // summary output register
   logic                       r_dst_rdy;
   logic [NCFG_BW-1:0]         r_o_id;
   logic [ABW-1:0]             r_o_linear;
   logic [VDIM-1:0][WBW-1:0]   r_o_bofs;
   logic [ST_BW-1:0]           r_o_ntap;
   logic                       r_o_retire;
   logic                       r_o_islast;
   logic                       r_o_err;

   logic [ST_BW-1:0]           w_beg;
   logic [ST_BW-1:0]           w_end_in;
   logic [ST_BW-1:0]           w_end_grp;
   logic [ST_BW-1:0]           w_end_sel;
   logic [ST_BW-1:0]           w_sid;
   logic [ST_BW-1:0]           w_sid_nxt;
   logic [ABW-1:0]             w_ofs;
   logic [ABW-1:0]             w_base;
   logic                       w_degen;
   logic                       w_closing;
   logic                       w_mismatch;
   logic                       w_flag_err;
   logic                       w_beat_err;
   logic                       w_src_ack;

   // Table lookups, base recovery, group-close and error detection for the current beat.
   always_comb begin
      w_beg     = '0;
      w_end_in  = '0;
      w_end_grp = '0;
      for (int k = 0; k < N_CFG; k++) begin
         w_beg     = (bus.i_id == NCFG_BW'(k)) ? i_stencil_begs[k] : w_beg;
         w_end_in  = (bus.i_id == NCFG_BW'(k)) ? i_stencil_ends[k] : w_end_in;
         w_end_grp = (r_id     == NCFG_BW'(k)) ? i_stencil_ends[k] : w_end_grp;
      end
      // a running group is closed against its captured id, a fresh one against the beat id
      w_end_sel = r_ingrp ? w_end_grp : w_end_in;
      w_sid     = r_ingrp ? r_sid : w_beg;
      w_sid_nxt = w_sid + ST_BW'(1);
      w_ofs     = '0;
      for (int j = 0; j < STSIZE; j++) begin
         w_ofs = (w_sid == ST_BW'(j)) ? i_stencil_lut[j] : w_ofs;
      end
      w_base     = bus.i_linear - (i_stencil ? w_ofs : {ABW{1'b0}});
      w_degen    = i_stencil && !r_ingrp && (w_beg >= w_end_in);
      w_closing  = !i_stencil || w_degen || (w_sid_nxt == w_end_sel);
      w_mismatch = r_ingrp && ((bus.i_id != r_id) || (bus.i_bofs != r_bofs) || (w_base != r_base));
      w_flag_err = (bus.i_retire || bus.i_islast) && !w_closing;
      w_beat_err = w_mismatch || w_flag_err || w_degen;
      // only a closing beat needs room in the output register
      w_src_ack  = bus.src_rdy && (!w_closing || !r_dst_rdy || bus.dst_ack);
   end

   assign bus.src_ack  = w_src_ack;
   assign bus.dst_rdy  = r_dst_rdy;
   assign bus.o_id     = r_o_id;
   assign bus.o_linear = r_o_linear;
   assign bus.o_bofs   = r_o_bofs;
   assign bus.o_ntap   = r_o_ntap;
   assign bus.o_retire = r_o_retire;
   assign bus.o_islast = r_o_islast;
   assign bus.o_err    = r_o_err;

   // Track the open group: capture on its first beat, accumulate on later non-closing beats.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ingrp   <= 1'b0;
         r_sid     <= '0;
         r_id      <= '0;
         r_bofs    <= '0;
         r_base    <= '0;
         r_cnt     <= '0;
         r_err_acc <= 1'b0;
      end else if (w_src_ack) begin
         if (w_closing) begin
            r_ingrp   <= 1'b0;
            r_sid     <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
         end else begin
            r_ingrp   <= 1'b1;
            r_sid     <= w_sid_nxt;
            r_cnt     <= r_ingrp ? (r_cnt + ST_BW'(1)) : ST_BW'(1);
            r_err_acc <= (r_ingrp && r_err_acc) || w_beat_err;
            if (!r_ingrp) begin
               r_id   <= bus.i_id;
               r_bofs <= bus.i_bofs;
               r_base <= w_base;
            end
         end
      end
   end

   // Load the summary register on an accepted closing beat; drop valid once consumed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dst_rdy  <= 1'b0;
         r_o_id     <= '0;
         r_o_linear <= '0;
         r_o_bofs   <= '0;
         r_o_ntap   <= '0;
         r_o_retire <= 1'b0;
         r_o_islast <= 1'b0;
         r_o_err    <= 1'b0;
      end else if (w_src_ack && w_closing) begin
         r_dst_rdy  <= 1'b1;
         r_o_id     <= r_ingrp ? r_id   : bus.i_id;
         r_o_bofs   <= r_ingrp ? r_bofs : bus.i_bofs;
         r_o_linear <= r_ingrp ? r_base : w_base;
         r_o_ntap   <= r_ingrp ? (r_cnt + ST_BW'(1)) : ST_BW'(1);
         r_o_retire <= bus.i_retire;
         r_o_islast <= bus.i_islast;
         r_o_err    <= (r_ingrp && r_err_acc) || w_beat_err;
      end else if (bus.dst_ack) begin
         r_dst_rdy  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_accum_warp_stencil_collect.sv
// Directed bench for accum_warp_stencil_collect. A group-level model turns
// each accepted beat list into the expected summary; a compare process checks
// the summary stream every cycle, and literal checks pin the model.
module tb_accum_warp_stencil_collect;
   localparam int N_CFG = 4, ABW = 32, WBW = 8, VDIM = 3, STSIZE = 8;

   typedef logic [VDIM-1:0][WBW-1:0] bofs_t;
   typedef struct {
      logic [2:0]  id;
      logic [31:0] linear;
      bofs_t       bofs;
      logic        retire;
      logic        islast;
   } beat_t;
   typedef struct {
      logic [2:0]  id;
      logic [31:0] linear;
      bofs_t       bofs;
      logic [3:0]  ntap;
      logic        retire;
      logic        islast;
      logic        err;
   } sum_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stencil;
   logic [N_CFG-1:0][3:0]   begs_p;
   logic [N_CFG-1:0][3:0]   ends_p;
   logic [STSIZE-1:0][31:0] lut_p;

   int          cfg_begs [N_CFG];
   int          cfg_ends [N_CFG];
   logic [31:0] cfg_lut  [STSIZE];

   int   total = 0;
   int   bad   = 0;
   beat_t grp_q[$];
   sum_t  exp_q[$];
   sum_t  last_sum;

   always #5 clk = ~clk;

   accum_warp_stencil_collect_if #(.N_CFG(N_CFG), .ABW(ABW), .WBW(WBW), .VDIM(VDIM), .STSIZE(STSIZE)) bus ();

   accum_warp_stencil_collect #(.N_CFG(N_CFG), .ABW(ABW), .WBW(WBW), .VDIM(VDIM), .STSIZE(STSIZE)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .bus            (bus),
      .i_stencil      (stencil),
      .i_stencil_begs (begs_p),
      .i_stencil_ends (ends_p),
      .i_stencil_lut  (lut_p)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ofs_of(input int k);
      if (!stencil || k < 0 || k >= STSIZE) return 32'h0;
      return cfg_lut[k];
   endfunction

   // Group-level model: gather beats, decide close from the tap range, summarise.
   task automatic model_accept(input beat_t b);
      int n, b0, e0;
      bit close, degen;
      sum_t s;
      logic [31:0] base0, bi;
      grp_q.push_back(b);
      n = grp_q.size();
      degen = 1'b0;
      b0 = 0;
      if (!stencil) begin
         close = 1'b1;
      end else begin
         b0    = cfg_begs[int'(grp_q[0].id)];
         e0    = cfg_ends[int'(grp_q[0].id)];
         degen = (n == 1) && (b0 >= e0);
         close = degen || (b0 + n == e0);
      end
      if (close) begin
         base0    = grp_q[0].linear - ofs_of(b0);
         s.id     = grp_q[0].id;
         s.bofs   = grp_q[0].bofs;
         s.linear = base0;
         s.ntap   = 4'(n);
         s.retire = grp_q[n-1].retire;
         s.islast = grp_q[n-1].islast;
         s.err    = degen;
         for (int i = 0; i < n; i++) begin
            bi = grp_q[i].linear - ofs_of(b0 + i);
            if (i > 0 && (grp_q[i].id != s.id || grp_q[i].bofs != s.bofs || bi != base0)) s.err = 1'b1;
            if (i < n - 1 && (grp_q[i].retire || grp_q[i].islast)) s.err = 1'b1;
         end
         exp_q.push_back(s);
         grp_q.delete();
      end
   endtask

   // Compare the summary stream against the model on every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (bus.dst_rdy !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL dst_rdy act=%0b exp=%0b t=%0t", bus.dst_rdy, (exp_q.size() != 0), $time);
         end
         if (bus.dst_rdy === 1'b1 && exp_q.size() != 0) begin
            total++;
            if (bus.o_id !== exp_q[0].id || bus.o_linear !== exp_q[0].linear || bus.o_bofs !== exp_q[0].bofs ||
                bus.o_ntap !== exp_q[0].ntap || bus.o_retire !== exp_q[0].retire ||
                bus.o_islast !== exp_q[0].islast || bus.o_err !== exp_q[0].err) begin
               bad++;
               $display("FAIL summary act id=%0d lin=%h bofs=%h ntap=%0d r=%0b l=%0b e=%0b exp id=%0d lin=%h bofs=%h ntap=%0d r=%0b l=%0b e=%0b t=%0t",
                        bus.o_id, bus.o_linear, bus.o_bofs, bus.o_ntap, bus.o_retire, bus.o_islast, bus.o_err,
                        exp_q[0].id, exp_q[0].linear, exp_q[0].bofs, exp_q[0].ntap, exp_q[0].retire,
                        exp_q[0].islast, exp_q[0].err, $time);
            end
            if (bus.dst_ack === 1'b1) last_sum = exp_q.pop_front();
         end
      end
   end

   function automatic beat_t mk(input logic [2:0] id, input logic [31:0] lin, input bofs_t bf,
                                input logic r, input logic l);
      beat_t b;
      b.id = id; b.linear = lin; b.bofs = bf; b.retire = r; b.islast = l;
      return b;
   endfunction

   // Entered and left at posedge+1.
   task automatic send_beat(input beat_t b, input bit expect_now, input int stall_n);
      bit got;
      bus.i_id     = b.id;
      bus.i_linear = b.linear;
      bus.i_bofs   = b.bofs;
      bus.i_retire = b.retire;
      bus.i_islast = b.islast;
      bus.src_rdy  = 1'b1;
      got = 1'b0;
      if (stall_n > 0) begin
         for (int n = 0; n < stall_n; n++) begin
            @(negedge clk);
            chk("stall_src_ack", bus.src_ack, 64'd0);
         end
         @(posedge clk);
         #1 bus.dst_ack = 1'b1;
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (expect_now && n == 0) chk("src_ack_now", bus.src_ack, 64'd1);
         if (bus.src_ack === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL src_ack_timeout act=0 exp=1 t=%0t", $time);
      end
      @(posedge clk);
      if (got) model_accept(b);
      #1 bus.src_rdy = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL drain_timeout act=%0d exp=0 t=%0t", exp_q.size(), $time);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.src_rdy = 1'b0;
      rst = 1'b1;
      grp_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_dst_rdy", bus.dst_rdy,  64'd0);
      chk("rst_o_id",    bus.o_id,     64'd0);
      chk("rst_o_lin",   bus.o_linear, 64'd0);
      chk("rst_o_bofs",  bus.o_bofs,   64'd0);
      chk("rst_o_ntap",  bus.o_ntap,   64'd0);
      chk("rst_o_flags", {bus.o_retire, bus.o_islast, bus.o_err}, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_group(input logic [31:0] base, input bofs_t bf, input bit imm);
      send_beat(mk(3'd0, base + 32'h10, bf, 1'b0, 1'b0), imm, 0);
      send_beat(mk(3'd0, base + 32'h20, bf, 1'b0, 1'b0), imm, 0);
      send_beat(mk(3'd0, base + 32'h30, bf, 1'b1, 1'b1), imm, 0);
   endtask

   initial begin
      bofs_t bf;
      bf = {8'h03, 8'h02, 8'h01};
      cfg_begs = '{1, 2, 0, 0};
      cfg_ends = '{4, 2, 1, 1};
      for (int j = 0; j < STSIZE; j++) cfg_lut[j] = 32'h10 * 32'(j);
      for (int k = 0; k < N_CFG; k++) begin
         begs_p[k] = 4'(cfg_begs[k]);
         ends_p[k] = 4'(cfg_ends[k]);
      end
      for (int j = 0; j < STSIZE; j++) lut_p[j] = cfg_lut[j];
      stencil      = 1'b1;
      bus.src_rdy  = 1'b0;
      bus.dst_ack  = 1'b1;
      bus.i_id     = 3'd0;
      bus.i_linear = 32'h0;
      bus.i_bofs   = '0;
      bus.i_retire = 1'b0;
      bus.i_islast = 1'b0;

      do_reset();

      // basic 3-tap stencil group
      send_group(32'h1000, bf, 1'b1);
      drain();
      chk("t1_model_lin",  last_sum.linear, 64'h1000);
      chk("t1_model_ntap", last_sum.ntap,   64'd3);
      chk("t1_model_flg",  {last_sum.retire, last_sum.islast, last_sum.err}, 64'b110);
      chk("t1_dut_lin",    bus.o_linear,    64'h1000);
      chk("t1_dut_ntap",   bus.o_ntap,      64'd3);

      // base mismatch on the middle beat, then a clean group
      send_beat(mk(3'd0, 32'h1010, bf, 1'b0, 1'b0), 1'b1, 0);
      send_beat(mk(3'd0, 32'h1021, bf, 1'b0, 1'b0), 1'b1, 0);
      send_beat(mk(3'd0, 32'h1030, bf, 1'b1, 1'b1), 1'b1, 0);
      drain();
      chk("t3_model_err",  last_sum.err,  64'd1);
      chk("t3_model_ntap", last_sum.ntap, 64'd3);
      chk("t3_dut_err",    bus.o_err,     64'd1);
      send_group(32'h1000, bf, 1'b1);
      drain();
      chk("t3_clean_err",  last_sum.err,  64'd0);

      // non-stencil stream: one summary per beat, no stalls
      stencil = 1'b0;
      for (int i = 0; i < 4; i++)
         send_beat(mk(3'd2, 32'h2000 + 32'(i), bf, 1'b0, 1'b0), 1'b1, 0);
      drain();
      chk("t2_model_lin",  last_sum.linear, 64'h2003);
      chk("t2_model_ntap", last_sum.ntap,   64'd1);
      stencil = 1'b1;

      // back-pressure: closing beat waits until the sink consumes
      bus.dst_ack = 1'b0;
      send_group(32'h4000, bf, 1'b1);
      send_beat(mk(3'd0, 32'h5010, bf, 1'b0, 1'b0), 1'b1, 0);
      send_beat(mk(3'd0, 32'h5020, bf, 1'b0, 1'b0), 1'b1, 0);
      send_beat(mk(3'd0, 32'h5030, bf, 1'b1, 1'b1), 1'b1, 3);
      drain();
      chk("t4_model_lin", last_sum.linear, 64'h5000);

      // reset in the middle of a group, then a full group
      send_beat(mk(3'd0, 32'h6010, bf, 1'b0, 1'b0), 1'b1, 0);
      send_beat(mk(3'd0, 32'h6020, bf, 1'b0, 1'b0), 1'b1, 0);
      do_reset();
      send_group(32'h7000, bf, 1'b1);
      drain();
      chk("t5_model_lin",  last_sum.linear, 64'h7000);
      chk("t5_model_ntap", last_sum.ntap,   64'd3);
      chk("t5_dut_lin",    bus.o_linear,    64'h7000);

      // degenerate tap range on config 1
      send_beat(mk(3'd1, 32'h3000, bf, 1'b0, 1'b0), 1'b1, 0);
      drain();
      chk("t6_model_ntap", last_sum.ntap,   64'd1);
      chk("t6_model_err",  last_sum.err,    64'd1);
      chk("t6_model_lin",  last_sum.linear, 64'h2FE0);
      chk("t6_dut_err",    bus.o_err,       64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished t=%0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
